// File: rtl/bist_seq_pkg.sv
// Shared types and constants for the BIST sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bist_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_ACCUM,
        S_FINISH
    } state_t;

    localparam int DEF_NUM_TASKS = 10;
    localparam int DEF_TIMEOUT   = 1000;
    localparam int DEF_ERR_W     = 16;

    // Add two counts, clamping at max_val instead of wrapping.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    endfunction

endpackage

// File: rtl/bist_seq_watchdog.sv
// Per-task WAIT watchdog: counts enabled cycles since clear, flags TIMEOUT-1.
// Latency: expired is combinational from the count register.
// Backpressure: none; the counter parks at TIMEOUT-1 until cleared.
module bist_watchdog
    import bist_seq_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt;

    assign expired = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bist_sequencer.sv
// Launches NUM_TASKS self-test tasks in order, sums their error counts, stops on a per-task timeout.
// Latency: next task_start fires 2 cycles after the current task_done; done pulses 2 cycles after the last one.
// Backpressure: start is ignored while busy; optional task skipping with BIST_SEQ_MASK_EN.
module bist_sequencer
    import bist_seq_pkg::*;
#(
    parameter int NUM_TASKS = DEF_NUM_TASKS,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int ERR_W     = DEF_ERR_W
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic [NUM_TASKS-1:0]                task_start,
    input  logic [NUM_TASKS-1:0]                task_done,
    input  logic [NUM_TASKS-1:0][ERR_W-1:0]     task_err,
`ifdef BIST_SEQ_MASK_EN
    input  logic [NUM_TASKS-1:0]                task_mask,
`endif
    output logic                                busy,
    output logic                                done,
    output logic                                pass,
    output logic                                timed_out,
    output logic [$clog2(NUM_TASKS)-1:0]        timed_out_idx,
    output logic [ERR_W-1:0]                    total_errors
);

    localparam int          IDX_W   = $clog2(NUM_TASKS);
    localparam logic [31:0] ERR_MAX = 32'((64'd1 << ERR_W) - 64'd1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   nxt_idx;
    logic               nxt_found;
    logic [NUM_TASKS-1:0] run_mask;
    logic               first_en;
    logic               wd_expired;
    logic [ERR_W-1:0]   sum_done;
    logic [ERR_W-1:0]   sum_to;

`ifdef BIST_SEQ_MASK_EN
    logic [NUM_TASKS-1:0] mask_q;

    assign run_mask = mask_q;
    assign first_en = task_mask[0];
`else
    assign run_mask = '1;
    assign first_en = 1'b1;
`endif

    assign sum_done = ERR_W'(sat_add(32'(total_errors), 32'(task_err[idx]), ERR_MAX));
    assign sum_to   = ERR_W'(sat_add(32'(total_errors), 32'd1, ERR_MAX));

    // Lowest enabled task above idx; masked tasks are jumped over from ACCUM.
    always_comb begin
        nxt_found = 1'b0;
        nxt_idx   = '0;
        for (int i = NUM_TASKS - 1; i >= 0; i--) begin
            if (i > int'(idx) && run_mask[i]) begin
                nxt_found = 1'b1;
                nxt_idx   = IDX_W'(i);
            end
        end
    end

    bist_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == S_LAUNCH),
        .enable  (state == S_WAIT),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            idx           <= '0;
            task_start    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timed_out     <= 1'b0;
            timed_out_idx <= '0;
            total_errors  <= '0;
`ifdef BIST_SEQ_MASK_EN
            mask_q        <= '0;
`endif
        end else begin
            task_start <= '0;
            done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx           <= '0;
                        total_errors  <= '0;
                        timed_out     <= 1'b0;
                        timed_out_idx <= '0;
                        pass          <= 1'b0;
                        busy          <= 1'b1;
                        task_start    <= first_en ? NUM_TASKS'(1) : '0;
`ifdef BIST_SEQ_MASK_EN
                        mask_q        <= task_mask;
`endif
                        state         <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    state <= run_mask[idx] ? S_WAIT : S_ACCUM;
                end
                S_WAIT: begin
                    // A completion in the expiry cycle wins over the timeout.
                    if (task_done[idx]) begin
                        total_errors <= sum_done;
                        state        <= S_ACCUM;
                    end else if (wd_expired) begin
                        total_errors  <= sum_to;
                        timed_out     <= 1'b1;
                        timed_out_idx <= idx;
                        pass          <= 1'b0;
                        done          <= 1'b1;
                        state         <= S_FINISH;
                    end
                end
                S_ACCUM: begin
                    if (nxt_found) begin
                        idx        <= nxt_idx;
                        task_start <= NUM_TASKS'(1) << nxt_idx;
                        state      <= S_LAUNCH;
                    end else begin
                        pass  <= (total_errors == '0) && !timed_out;
                        done  <= 1'b1;
                        state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bist_sequencer.sv
// Directed bench for bist_sequencer: table of whole-sequence vectors plus hand sequences
// for reset, saturation, done/timeout coincidence, stray completions and the optional mask.
module tb_bist_sequencer;

    localparam int NT  = 10;
    localparam int TO  = 1000;
    localparam int EW  = 16;
    localparam int DLY = 5;

    logic clk;
    logic rst;

    // Main instance (default parameters)
    logic                    start;
    logic [NT-1:0]           task_start;
    logic [NT-1:0]           task_done;
    logic [NT-1:0][EW-1:0]   task_err;
    logic                    busy, done, pass, timed_out;
    logic [3:0]              timed_out_idx;
    logic [EW-1:0]           total_errors;

    // Narrow-count instance with a short watchdog
    logic                    start4;
    logic [NT-1:0]           ts4;
    logic [NT-1:0]           td4;
    logic [NT-1:0][3:0]      te4;
    logic                    busy4, done4, pass4, to4;
    logic [3:0]              toi4;
    logic [3:0]              tot4;

`ifdef BIST_SEQ_MASK_EN
    logic [NT-1:0]           task_mask;
    logic [NT-1:0]           mask4;
`endif

    bist_sequencer #(.NUM_TASKS(NT), .TIMEOUT(TO), .ERR_W(EW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .task_start    (task_start),
        .task_done     (task_done),
        .task_err      (task_err),
`ifdef BIST_SEQ_MASK_EN
        .task_mask     (task_mask),
`endif
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .timed_out     (timed_out),
        .timed_out_idx (timed_out_idx),
        .total_errors  (total_errors)
    );

    bist_sequencer #(.NUM_TASKS(NT), .TIMEOUT(16), .ERR_W(4)) dut4 (
        .clk           (clk),
        .rst           (rst),
        .start         (start4),
        .task_start    (ts4),
        .task_done     (td4),
        .task_err      (te4),
`ifdef BIST_SEQ_MASK_EN
        .task_mask     (mask4),
`endif
        .busy          (busy4),
        .done          (done4),
        .pass          (pass4),
        .timed_out     (to4),
        .timed_out_idx (toi4),
        .total_errors  (tot4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [NT-1:0][EW-1:0] errs;
        int hang;          // task that never completes, -1 for none
        int exp_total;
        int exp_pass;
        int exp_to;
        int exp_idx;
        int exp_launch;
    } vec_t;

    vec_t vt[5];

    int n_vec = 0;
    int n_bad = 0;

    int cyc = 0;
    int l_idx[$];
    int l_cyc[NT];
    int done_cyc[NT];
    int n_done;
    int onehot_bad;
    int to_cyc;
    logic pass_at_done;

    logic [NT-1:0]         inject;
    logic [NT-1:0][EW-1:0] cfg_err;
    int                    hang;
    bit                    pend[NT];
    int                    rcnt[NT];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Observer of the main instance.
    initial forever begin
        @(negedge clk);
        if (task_start != '0) begin
            if ($countones(task_start) != 1) onehot_bad++;
            for (int i = 0; i < NT; i++) begin
                if (task_start[i]) begin
                    l_idx.push_back(i);
                    l_cyc[i] = cyc;
                end
            end
        end
        if (done) begin
            n_done++;
            pass_at_done = pass;
        end
        if (timed_out && to_cyc < 0) to_cyc = cyc;
    end

    // Task model: completes DLY cycles after its launch pulse.
    initial forever begin
        @(negedge clk);
        task_done = inject;
        task_err  = cfg_err;
        for (int i = 0; i < NT; i++) begin
            if (rst) begin
                pend[i] = 1'b0;
            end else if (pend[i]) begin
                if (rcnt[i] == 0) begin
                    task_done[i] = 1'b1;
                    pend[i]      = 1'b0;
                    done_cyc[i]  = cyc;
                end else begin
                    rcnt[i]--;
                end
            end
            if (!rst && task_start[i] && i != hang) begin
                pend[i] = 1'b1;
                rcnt[i] = DLY - 1;
            end
        end
    end

    task automatic clear_rec();
        l_idx.delete();
        for (int i = 0; i < NT; i++) begin
            l_cyc[i]    = -1;
            done_cyc[i] = -1;
        end
        n_done     = 0;
        onehot_bad = 0;
        to_cyc     = -1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int w;
        w = 0;
        while (n_done == 0 && w < limit) begin
            @(negedge clk);
            w++;
        end
    endtask

    task automatic run_vec(input int k);
        cfg_err = vt[k].errs;
        hang    = vt[k].hang;
        clear_rec();
        pulse_start();
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d_busy_mid", k), 32'(busy), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(TO + 200);
        repeat (20) @(negedge clk);
        chk($sformatf("v%0d_done_pulses", k), 32'(n_done), 32'd1);
        chk($sformatf("v%0d_total", k), 32'(total_errors), 32'(vt[k].exp_total));
        chk($sformatf("v%0d_pass", k), 32'(pass_at_done), 32'(vt[k].exp_pass));
        chk($sformatf("v%0d_pass_hold", k), 32'(pass), 32'(vt[k].exp_pass));
        chk($sformatf("v%0d_timed_out", k), 32'(timed_out), 32'(vt[k].exp_to));
        chk($sformatf("v%0d_to_idx", k), 32'(timed_out_idx), 32'(vt[k].exp_idx));
        chk($sformatf("v%0d_launches", k), 32'(l_idx.size()), 32'(vt[k].exp_launch));
        chk($sformatf("v%0d_onehot", k), 32'(onehot_bad), 32'd0);
        chk($sformatf("v%0d_busy_end", k), 32'(busy), 32'd0);
        for (int j = 0; j < l_idx.size(); j++)
            chk($sformatf("v%0d_order%0d", k, j), 32'(l_idx[j]), 32'(j));
        for (int j = 1; j < l_idx.size(); j++)
            chk($sformatf("v%0d_gap%0d", k, j), 32'(l_cyc[j] - done_cyc[j-1]), 32'd2);
        if (vt[k].hang >= 0)
            chk($sformatf("v%0d_to_latency", k), 32'(to_cyc - l_cyc[vt[k].hang]), 32'(TO + 1));
    endtask

    task automatic run_dut4();
        int w;
        int d2;
        int launches4;
        launches4 = 0;
        d2 = 0;
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        for (int i = 0; i < NT; i++) begin
            w = 0;
            while (!ts4[i] && w < 40) begin
                @(negedge clk);
                w++;
            end
            if (!ts4[i]) begin
                chk($sformatf("w4_launch%0d", i), 32'(ts4[i]), 32'd1);
                break;
            end
            launches4++;
            if (i == 3) chk("w4_gap_after_coincident", 32'(cyc - d2), 32'd2);
            if (i == 2) begin
                // Complete exactly in the watchdog's expiry cycle, with a stray bit on the way.
                for (int k = 1; k <= 16; k++) begin
                    @(negedge clk);
                    td4 = '0;
                    te4 = '0;
                    if (k == 3) begin
                        td4[8] = 1'b1;
                        te4[8] = 4'd5;
                    end
                    if (k == 16) begin
                        td4[2] = 1'b1;
                        d2     = cyc;
                    end
                end
            end else begin
                @(negedge clk);
                td4[i] = 1'b1;
                te4[i] = (i == 0) ? 4'd15 : (i == 1) ? 4'd3 : 4'd0;
            end
            @(negedge clk);
            td4 = '0;
            te4 = '0;
        end
        w = 0;
        while (!done4 && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("w4_done", 32'(done4), 32'd1);
        chk("w4_total_sat", 32'(tot4), 32'd15);
        chk("w4_timed_out", 32'(to4), 32'd0);
        chk("w4_pass", 32'(pass4), 32'd0);
        chk("w4_launches", 32'(launches4), 32'd10);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: bench did not complete");
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        start4  = 1'b0;
        td4     = '0;
        te4     = '0;
        inject  = '0;
        cfg_err = '0;
        hang    = -1;
`ifdef BIST_SEQ_MASK_EN
        task_mask = '1;
        mask4     = '1;
`endif
        for (int k = 0; k < 5; k++) begin
            vt[k].errs       = '0;
            vt[k].hang       = -1;
            vt[k].exp_total  = 0;
            vt[k].exp_pass   = 1;
            vt[k].exp_to     = 0;
            vt[k].exp_idx    = 0;
            vt[k].exp_launch = 10;
        end
        vt[1].errs[3] = 16'd4;
        vt[1].errs[7] = 16'd2;
        vt[1].exp_total = 6;
        vt[1].exp_pass  = 0;
        vt[2].errs[1] = 16'd3;
        vt[2].hang       = 5;
        vt[2].exp_total  = 4;
        vt[2].exp_pass   = 0;
        vt[2].exp_to     = 1;
        vt[2].exp_idx    = 5;
        vt[2].exp_launch = 6;
        vt[3].errs[0] = 16'hFFF0;
        vt[3].errs[1] = 16'h0020;
        vt[3].exp_total = 65535;
        vt[3].exp_pass  = 0;
        clear_rec();

        repeat (3) @(negedge clk);
        chk("rst_task_start", 32'(task_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_timed_out", 32'(timed_out), 32'd0);
        chk("rst_to_idx", 32'(timed_out_idx), 32'd0);
        chk("rst_total", 32'(total_errors), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_release_no_launch", 32'(l_idx.size()), 32'd0);

        for (int k = 0; k < 5; k++) run_vec(k);

        // Completions while idle must not touch the held result.
        clear_rec();
        cfg_err = '1;
        inject  = '1;
        repeat (3) @(negedge clk);
        inject  = '0;
        cfg_err = '0;
        repeat (2) @(negedge clk);
        chk("idle_done_total", 32'(total_errors), 32'd0);
        chk("idle_done_busy", 32'(busy), 32'd0);
        chk("idle_done_launch", 32'(l_idx.size()), 32'd0);

        // Reset while waiting on task 4.
        clear_rec();
        cfg_err    = '0;
        cfg_err[1] = 16'd2;
        hang       = -1;
        pulse_start();
        for (int w = 0; w < 100 && l_idx.size() < 5; w++) @(negedge clk);
        chk("mid_reached_task4", 32'(l_idx.size()), 32'd5);
        repeat (2) @(negedge clk);
        chk("mid_busy_before", 32'(busy), 32'd1);
        chk("mid_total_before", 32'(total_errors), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_total", 32'(total_errors), 32'd0);
        chk("mid_rst_task_start", 32'(task_start), 32'd0);
        chk("mid_rst_flags", 32'({done, pass, timed_out}), 32'd0);
        chk("mid_rst_to_idx", 32'(timed_out_idx), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        clear_rec();
        repeat (3) @(negedge clk);
        chk("mid_release_no_launch", 32'(l_idx.size()), 32'd0);
        run_vec(0);

        run_dut4();

`ifdef BIST_SEQ_MASK_EN
        begin
            int exp_ord[8];
            exp_ord = '{0, 2, 4, 5, 6, 7, 8, 9};
            clear_rec();
            cfg_err   = '0;
            hang      = -1;
            task_mask = 10'h3F5;
            pulse_start();
            task_mask = '1;
            wait_done(400);
            repeat (5) @(negedge clk);
            chk("mask_launches", 32'(l_idx.size()), 32'd8);
            for (int j = 0; j < 8 && j < l_idx.size(); j++)
                chk($sformatf("mask_order%0d", j), 32'(l_idx[j]), 32'(exp_ord[j]));
            chk("mask_gap_0_to_2", 32'(l_cyc[2] - done_cyc[0]), 32'd2);
            chk("mask_pass", 32'(pass_at_done), 32'd1);
            chk("mask_total", 32'(total_errors), 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bist_sequencer.md
BIST_SEQUENCER -- requirements
Module: bist_sequencer

Interface
REQ-001 SHALL have parameter NUM_TASKS, default 10, number of sequenced subsystem tasks (2..32).
REQ-002 SHALL have parameter TIMEOUT, default 1000, maximum WAIT cycles per task (>=2).
REQ-003 SHALL have parameter ERR_W, default 16, width of the error counts.
REQ-004 SHALL have port clk  input  1  sole clock; one clock, reset asynchronous and active-high.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port start  input  1  single-cycle request to run the sequence.
REQ-007 SHALL have port task_start  output  NUM_TASKS  one-hot, single-cycle launch pulse per task.
REQ-008 SHALL have port task_done  input  NUM_TASKS  per-task completion pulse.
REQ-009 SHALL have port task_err  input  NUM_TASKS x ERR_W  per-task error count, valid with task_done.
REQ-010 SHALL have ports busy (1), done (1), pass (1), timed_out (1), timed_out_idx ($clog2(NUM_TASKS)), total_errors (ERR_W), all outputs.

Function
REQ-011 SHALL implement FSM states IDLE, LAUNCH, WAIT, ACCUM, FINISH.
REQ-012 IDLE: start high -> idx=0, clear total_errors/timed_out/timed_out_idx/pass, go LAUNCH; busy high from next cycle until FINISH ends.
REQ-013 LAUNCH: task_start[idx] high for exactly this cycle, watchdog cleared, go WAIT.
REQ-014 WAIT: watchdog increments each cycle; task_done[idx] high -> total_errors += task_err[idx], go ACCUM.
REQ-015 WAIT: watchdog reaching TIMEOUT-1 with task_done[idx] low -> total_errors += 1, timed_out=1, timed_out_idx=idx, go FINISH; remaining tasks are never launched.
REQ-016 task_done[idx] and timeout in the same cycle SHALL count as done (no timeout).
REQ-017 ACCUM: idx==NUM_TASKS-1 -> FINISH, else idx+1 and LAUNCH; task_start[i+1] therefore fires exactly 2 cycles after task_done[i].
REQ-018 FINISH: done high one cycle, pass = (total_errors==0 && !timed_out), go IDLE; pass/total_errors/timed_out/timed_out_idx hold until next accepted start.
REQ-019 Accumulation SHALL saturate at 2^ERR_W-1, never wrap.
REQ-020 task_done bits other than idx, and any task_done outside WAIT, SHALL be ignored.
REQ-021 start outside IDLE SHALL be ignored.

Reset
REQ-022 rst SHALL asynchronously force IDLE, idx=0, watchdog=0, all outputs 0, including mid-sequence; no task_start pulse SHALL be emitted during or on release of reset.

Configuration
REQ-023 With macro BIST_SEQ_MASK_EN defined, SHALL add input task_mask (NUM_TASKS); masked-off tasks are skipped (LAUNCH bypassed directly to ACCUM, no task_start, zero error contribution); mask sampled once on accepted start.
REQ-024 Without BIST_SEQ_MASK_EN, port task_mask SHALL not exist and all tasks run.

Structure
REQ-025 SHALL place the state enum, default parameter constants and saturating-add function in package bist_seq_pkg.
REQ-026 SHALL implement the per-task timeout counter as sub-module bist_watchdog (clear, enable, expired).

Verification
REQ-027 All 10 tasks done 5 cycles after launch, err=0 -> task_start pulses in order 0..9, done once, pass=1, total_errors=0, timed_out=0.
REQ-028 task 3 err=4, task 7 err=2 -> total_errors=6, pass=0, timed_out=0.
REQ-029 task 5 never done -> timed_out=1 exactly TIMEOUT=1000 cycles after WAIT entry, timed_out_idx=5, total_errors=prior+1, tasks 6..9 never started.
REQ-030 ERR_W=4, errs 15 then 3 -> total_errors=15; done and timeout coincident on task 2 -> timed_out=0; stray task_done[8] while waiting on task 2 ignored.
REQ-031 rst asserted in WAIT of task 4 -> all outputs 0 same cycle; subsequent start relaunches task 0.
REQ-032 With BIST_SEQ_MASK_EN, task_mask=10'h3F5 -> tasks 1 and 3 never started, task_start[2] 2 cycles after task_done[0], pass=1.
